// File: rtl/binary_game_pkg.sv
// Shared types, glyph constants and helpers for the binary counting game.
// The LFSR step lives here so every user advances it identically.
package binary_game_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHOW,
        RESULT
    } state_t;

    localparam logic [6:0] SEG_DASH  = 7'h40;
    localparam logic [6:0] SEG_PASS  = 7'h73;
    localparam logic [6:0] SEG_FAIL  = 7'h71;
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    // Segment order is {g,f,e,d,c,b,a}, active-high.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'h3F;
            4'h1:    seg = 7'h06;
            4'h2:    seg = 7'h5B;
            4'h3:    seg = 7'h4F;
            4'h4:    seg = 7'h66;
            4'h5:    seg = 7'h6D;
            4'h6:    seg = 7'h7D;
            4'h7:    seg = 7'h07;
            4'h8:    seg = 7'h7F;
            4'h9:    seg = 7'h6F;
            4'hA:    seg = 7'h77;
            4'hB:    seg = 7'h7C;
            4'hC:    seg = 7'h39;
            4'hD:    seg = 7'h5E;
            4'hE:    seg = 7'h79;
            default: seg = 7'h71;
        endcase
        return seg;
    endfunction

    // Galois form of x^8+x^6+x^5+x^4+1; a nonzero state never reaches zero.
    function automatic logic [7:0] lfsr_next(input logic [7:0] value);
        return value[0] ? ((value >> 1) ^ LFSR_TAPS) : (value >> 1);
    endfunction

endpackage

// File: rtl/button_debounce.sv
// Two-flop synchroniser, stability counter and rising-edge pulse for one push button.
module button_debounce #(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ena,
    input  logic button,
    output logic press
);

    logic        sync_a;
    logic        sync_b;
    logic        level;
    logic [15:0] stable_cnt;
    logic        settle;

    // The synchroniser keeps sampling while frozen so the level is current on resume.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_a <= 1'b0;
            sync_b <= 1'b0;
        end else begin
            sync_a <= button;
            sync_b <= sync_a;
        end
    end

    assign settle = (sync_b != level) && (stable_cnt == DEBOUNCE_CYCLES - 16'd1);
    assign press  = ena && settle && sync_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level      <= 1'b0;
            stable_cnt <= 16'd0;
        end else if (ena) begin
            if (sync_b == level) begin
                stable_cnt <= 16'd0;
            end else if (settle) begin
                level      <= sync_b;
                stable_cnt <= 16'd0;
            end else begin
                stable_cnt <= stable_cnt + 16'd1;
            end
        end
    end

endmodule

// File: rtl/binary_challenge_ctrl.sv
// Challenge side of the binary counting game: target generation, two-digit display,
// grading of the submitted DIP value and streak score.
module binary_challenge_ctrl
    import binary_game_pkg::*;
#(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
    parameter logic [23:0] DIGIT_CYCLES    = 24'd2000000,
    parameter logic [25:0] RESULT_CYCLES   = 26'd20000000,
    parameter logic [7:0]  LFSR_SEED       = 8'hA5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    logic        press;
    logic [7:0]  ui_a;
    logic [7:0]  ui_b;
    logic        unused_ok;

    state_t      state,      state_n;
    logic [7:0]  target,     target_n;
    logic        phase_high, phase_high_n;
    logic [23:0] digit_cnt,  digit_cnt_n;
    logic [25:0] result_cnt, result_cnt_n;
    logic        pass,       pass_n;
    logic [3:0]  score,      score_n;
    logic [7:0]  lfsr;
    logic [7:0]  disp_n;
    logic [7:0]  uo_q;
    logic [7:0]  uio_q;

    assign unused_ok = &{1'b0, uio_in[7:1]};
    assign uio_oe    = 8'hF0;
    assign uo_out    = uo_q;
    assign uio_out   = uio_q;

    button_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_submit (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .button(uio_in[0]),
        .press (press)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ui_a <= 8'h00;
            ui_b <= 8'h00;
        end else begin
            ui_a <= ui_in;
            ui_b <= ui_a;
        end
    end

    // Grading and score update happen on the same edge that enters RESULT.
    always_comb begin
        state_n      = state;
        target_n     = target;
        phase_high_n = phase_high;
        digit_cnt_n  = digit_cnt;
        result_cnt_n = result_cnt;
        pass_n       = pass;
        score_n      = score;
        case (state)
            IDLE: begin
                if (press) begin
                    state_n      = SHOW;
                    target_n     = lfsr;
                    phase_high_n = 1'b1;
                    digit_cnt_n  = 24'd0;
                end
            end
            SHOW: begin
                if (press) begin
                    state_n      = RESULT;
                    result_cnt_n = 26'd0;
                    pass_n       = (ui_b == target);
                    if (ui_b != target) begin
                        score_n = 4'd0;
                    end else if (score != 4'd15) begin
                        score_n = score + 4'd1;
                    end
                end else if (digit_cnt == DIGIT_CYCLES - 24'd1) begin
                    digit_cnt_n  = 24'd0;
                    phase_high_n = ~phase_high;
                end else begin
                    digit_cnt_n = digit_cnt + 24'd1;
                end
            end
            RESULT: begin
                if (result_cnt == RESULT_CYCLES - 26'd1) begin
                    state_n      = SHOW;
                    target_n     = lfsr;
                    phase_high_n = 1'b1;
                    digit_cnt_n  = 24'd0;
                    result_cnt_n = 26'd0;
                end else begin
                    result_cnt_n = result_cnt + 26'd1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        disp_n = {1'b0, SEG_DASH};
        case (state)
            SHOW:    disp_n = {phase_high, hex_to_seg(phase_high ? target[7:4] : target[3:0])};
            RESULT:  disp_n = {1'b0, pass ? SEG_PASS : SEG_FAIL};
            default: disp_n = {1'b0, SEG_DASH};
        endcase
    end

    // Everything except the input synchronisers holds while ena is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            target     <= 8'h00;
            phase_high <= 1'b1;
            digit_cnt  <= 24'd0;
            result_cnt <= 26'd0;
            pass       <= 1'b0;
            score      <= 4'd0;
            lfsr       <= LFSR_SEED;
            uo_q       <= {1'b0, SEG_DASH};
            uio_q      <= 8'h00;
        end else if (ena) begin
            state      <= state_n;
            target     <= target_n;
            phase_high <= phase_high_n;
            digit_cnt  <= digit_cnt_n;
            result_cnt <= result_cnt_n;
            pass       <= pass_n;
            score      <= score_n;
            lfsr       <= lfsr_next(lfsr);
            uo_q       <= disp_n;
            uio_q      <= {score, 4'h0};
        end
    end

endmodule
